// File: rtl/mole_hit_capture.sv
// Player-side button front end for the whack-a-mole core.
// Nine push buttons are synchronised, debounced and edge-detected. Presses are
// held in a per-channel pending vector, arbitrated lowest-index-first into a
// small first-word-fall-through queue, and handed to the game core over a
// valid/ready handshake. hit_valid/hit_idx are registered copies of the queue
// head, updated from the next-state of the queue.
module mole_hit_capture #(
  parameter int N_BTN           = 9,
  parameter int IDX_W           = 4,
  parameter int DEB_CYCLES      = 100000,
  parameter int FIFO_DEPTH      = 4,
  parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic                          cin,
  input  logic                          reset_n,
  input  logic [N_BTN-1:0]              btn_raw,
  input  logic                          enable,
  input  logic                          flush,
  output logic [N_BTN-1:0]              held,
  output logic                          hit_valid,
  output logic [IDX_W-1:0]              hit_idx,
  input  logic                          hit_ready,
  output logic [$clog2(FIFO_DEPTH):0]   hit_count,
  output logic                          overflow
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [N_BTN-1:0] btn_norm_s;
  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] held_r;
  logic [N_BTN-1:0] held_next_s;
  logic [N_BTN-1:0] rise_s;
  logic [N_BTN-1:0] set_s;
  logic [N_BTN-1:0] grant_s;
  logic [N_BTN-1:0] pending_r;
  logic [N_BTN-1:0] pending_next_s;
  logic [DEB_W-1:0] deb_cnt_r      [N_BTN];
  logic [DEB_W-1:0] deb_cnt_next_s [N_BTN];

  logic             overflow_r;
  logic             overflow_next_s;

  logic [IDX_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             hit_valid_r;
  logic             hit_valid_next_s;
  logic [IDX_W-1:0] hit_idx_r;
  logic [IDX_W-1:0] hit_idx_next_s;

  logic [IDX_W-1:0] push_idx_s;
  logic             any_pend_s;
  logic             push_s;
  logic             pop_s;

  // Normalise polarity so everything downstream sees 1 = pressed.
  assign btn_norm_s = BTN_ACTIVE_HIGH ? btn_raw : ~btn_raw;

  // Two-flop synchroniser on every button channel.
  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= btn_norm_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: a new level must persist DEB_CYCLES cycles; any return to the held level restarts.
  always_comb begin
    held_next_s = held_r;
    rise_s      = '0;
    for (int i = 0; i < N_BTN; i++) begin
      deb_cnt_next_s[i] = '0;
      if (sync2_r[i] != held_r[i]) begin
        if (deb_cnt_r[i] == DEB_LAST) begin
          held_next_s[i] = sync2_r[i];
          rise_s[i]      = sync2_r[i];
        end else begin
          deb_cnt_next_s[i] = deb_cnt_r[i] + DEB_W'(1);
        end
      end else begin
        deb_cnt_next_s[i] = '0;
      end
    end
  end

  // Debounce state registers; flush deliberately leaves these alone.
  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      held_r <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      held_r <= held_next_s;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_r[i] <= deb_cnt_next_s[i];
      end
    end
  end

  // Press edges are taken from the debounce accept itself, so pending rises with held.
  assign set_s = rise_s & {N_BTN{enable}};

  // Fixed-priority arbiter: lowest set pending bit wins.
  always_comb begin
    push_idx_s = '0;
    grant_s    = '0;
    any_pend_s = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!any_pend_s && pending_r[i]) begin
        any_pend_s    = 1'b1;
        push_idx_s    = IDX_W'(i);
        grant_s[i]    = 1'b1;
      end else begin
        any_pend_s = any_pend_s;
      end
    end
  end

  assign pop_s  = hit_valid_r & hit_ready;
  assign push_s = any_pend_s & ((count_r != CNT_FULL) | pop_s);

  // Pending vector and sticky overflow; a press on an already-pending channel is dropped.
  always_comb begin
    if (flush) begin
      pending_next_s  = '0;
      overflow_next_s = 1'b0;
    end else begin
      pending_next_s  = (pending_r & ~(grant_s & {N_BTN{push_s}})) | set_s;
      overflow_next_s = overflow_r | (|(set_s & pending_r));
    end
  end

  // Pending and overflow registers.
  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      pending_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      pending_r  <= pending_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  // Queue next-state, including the head value that the registered outputs will show.
  always_comb begin
    wr_ptr_next_s    = wr_ptr_r;
    rd_ptr_next_s    = rd_ptr_r;
    count_next_s     = count_r;
    hit_valid_next_s = 1'b0;
    hit_idx_next_s   = '0;
    if (flush) begin
      wr_ptr_next_s = '0;
      rd_ptr_next_s = '0;
      count_next_s  = '0;
    end else begin
      wr_ptr_next_s = push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
      rd_ptr_next_s = pop_s  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CNT_W'(1);
        2'b01:   count_next_s = count_r - CNT_W'(1);
        default: count_next_s = count_r;
      endcase
      hit_valid_next_s = (count_next_s != CNT_W'(0));
      if (!hit_valid_next_s) begin
        hit_idx_next_s = '0;
      end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
        // The new head is the entry being written this very cycle.
        hit_idx_next_s = push_idx_s;
      end else begin
        hit_idx_next_s = mem_r[rd_ptr_next_s];
      end
    end
  end

  // Queue storage: written at the write pointer on every accepted push.
  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_idx_s;
    end
  end

  // Queue pointers, occupancy and registered head outputs.
  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      hit_valid_r <= 1'b0;
      hit_idx_r   <= '0;
    end else begin
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      hit_valid_r <= hit_valid_next_s;
      hit_idx_r   <= hit_idx_next_s;
    end
  end

  assign held      = held_r;
  assign hit_valid = hit_valid_r;
  assign hit_idx   = hit_idx_r;
  assign hit_count = count_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_mole_hit_capture.sv
// Bench for mole_hit_capture with a short debounce window (8 cycles).
// Expected hit indices go into a scoreboard queue when buttons are driven and
// are popped each time the DUT completes a valid/ready transfer.
module tb_mole_hit_capture;

  localparam int N_BTN = 9;
  localparam int IDX_W = 4;
  localparam int DEB   = 8;
  localparam int DEPTH = 4;

  logic              cin       = 1'b0;
  logic              reset_n   = 1'b0;
  logic [N_BTN-1:0]  btn_raw   = '0;
  logic              enable    = 1'b1;
  logic              flush     = 1'b0;
  logic              hit_ready = 1'b1;
  logic [N_BTN-1:0]  held;
  logic              hit_valid;
  logic [IDX_W-1:0]  hit_idx;
  logic [2:0]        hit_count;
  logic              overflow;

  int n_vec   = 0;
  int n_err   = 0;
  int pop_cnt = 0;
  int sb[$];

  typedef struct {
    logic [N_BTN-1:0] mask;
    logic             en;
    logic [N_BTN-1:0] exp_held;
    int               exp_hits;
  } vec_t;

  vec_t vecs [5];

  mole_hit_capture #(
    .N_BTN(N_BTN), .IDX_W(IDX_W), .DEB_CYCLES(DEB),
    .FIFO_DEPTH(DEPTH), .BTN_ACTIVE_HIGH(1'b1)
  ) dut (
    .cin(cin), .reset_n(reset_n), .btn_raw(btn_raw), .enable(enable),
    .flush(flush), .held(held), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .hit_ready(hit_ready), .hit_count(hit_count), .overflow(overflow)
  );

  always #5 cin = ~cin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard check, sampled mid-cycle.
  task automatic mon();
    int e;
    if (reset_n && !flush) begin
      if (hit_valid && hit_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_hit", 32'(hit_idx), 32'd99);
        end else begin
          e = sb.pop_front();
          chk("hit_idx_order", 32'(hit_idx), 32'(e));
          pop_cnt++;
        end
      end else if (!hit_valid) begin
        chk("idle_idx_zero", 32'(hit_idx), 32'd0);
      end
    end
  endtask

  // Advance n clock edges; ends 1 time unit after the last rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge cin);
      mon();
      @(posedge cin);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (sb.size() == 0 && hit_count == 3'd0) break;
      tick(1);
    end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_count_zero", 32'(hit_count), 32'd0);
  endtask

  initial begin
    vecs[0] = '{9'h084, 1'b1, 9'h084, 2};   // buttons 7 and 2 together
    vecs[1] = '{9'h001, 1'b1, 9'h001, 1};   // lowest index
    vecs[2] = '{9'h100, 1'b1, 9'h100, 1};   // highest index
    vecs[3] = '{9'h1FF, 1'b1, 9'h1FF, 9};   // all nine, more than queue depth
    vecs[4] = '{9'h040, 1'b0, 9'h040, 0};   // enable low: held tracks, no hit

    // Reset state
    tick(3);
    chk("rst_held", 32'(held), 32'd0);
    chk("rst_valid", 32'(hit_valid), 32'd0);
    chk("rst_idx", 32'(hit_idx), 32'd0);
    chk("rst_count", 32'(hit_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick(3);

    // Clean press of btn 3: held at edge 10, hit visible one cycle later
    btn_raw[3] = 1'b1;
    sb.push_back(3);
    tick(9);
    chk("clean_held_early", 32'(held), 32'd0);
    tick(1);
    chk("clean_held_rise", 32'(held), 32'h008);
    chk("clean_valid_early", 32'(hit_valid), 32'd0);
    tick(1);
    chk("clean_valid", 32'(hit_valid), 32'd1);
    chk("clean_idx", 32'(hit_idx), 32'd3);
    chk("clean_count", 32'(hit_count), 32'd1);
    tick(1);
    chk("clean_valid_drop", 32'(hit_valid), 32'd0);
    btn_raw[3] = 1'b0;
    tick(12);
    chk("clean_release_held", 32'(held), 32'd0);
    chk("clean_release_count", 32'(hit_count), 32'd0);

    // Bounce on btn 5, then a stable press
    for (int k = 0; k < 6; k++) begin
      btn_raw[5] = ~btn_raw[5];
      tick(3);
      chk("bounce_held_low", 32'(held), 32'd0);
    end
    btn_raw[5] = 1'b1;
    sb.push_back(5);
    pop_cnt = 0;
    tick(9);
    chk("bounce_held_early", 32'(held), 32'd0);
    tick(1);
    chk("bounce_held_rise", 32'(held), 32'h020);
    drain(10);
    chk("bounce_one_hit", 32'(pop_cnt), 32'd1);
    btn_raw = '0;
    tick(12);

    // Table-driven presses
    for (int v = 0; v < 5; v++) begin
      enable  = vecs[v].en;
      pop_cnt = 0;
      btn_raw = vecs[v].mask;
      if (vecs[v].en) begin
        for (int b = 0; b < N_BTN; b++) begin
          if (vecs[v].mask[b]) sb.push_back(b);
        end
      end
      tick(10);
      chk("vec_held_rise", 32'(held), 32'(vecs[v].exp_held));
      drain(40);
      chk("vec_hit_total", 32'(pop_cnt), 32'(vecs[v].exp_hits));
      btn_raw = '0;
      tick(11);
      chk("vec_held_fall", 32'(held), 32'd0);
      enable = 1'b1;
    end

    // Full queue, pending wait, then overflow on a repeated channel
    hit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_raw[i] = 1'b1;
      sb.push_back(i);
      tick(11);
      btn_raw[i] = 1'b0;
      tick(11);
    end
    chk("full_count", 32'(hit_count), 32'd4);
    chk("full_head", 32'(hit_idx), 32'd0);
    chk("full_no_overflow", 32'(overflow), 32'd0);
    btn_raw[4] = 1'b1;
    tick(11);
    chk("overflow_set", 32'(overflow), 32'd1);
    btn_raw[4] = 1'b0;
    tick(11);
    hit_ready = 1'b1;
    pop_cnt   = 0;
    drain(20);
    chk("overflow_drain_hits", 32'(pop_cnt), 32'd5);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Flush with a same-cycle press and pop
    hit_ready = 1'b0;
    btn_raw   = 9'h007;
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(2);
    tick(14);
    chk("flush_pre_count", 32'(hit_count), 32'd3);
    btn_raw[6] = 1'b1;
    tick(9);
    flush     = 1'b1;
    hit_ready = 1'b1;
    tick(1);
    flush = 1'b0;
    sb.delete();
    chk("flush_count", 32'(hit_count), 32'd0);
    chk("flush_valid", 32'(hit_valid), 32'd0);
    chk("flush_idx", 32'(hit_idx), 32'd0);
    chk("flush_overflow", 32'(overflow), 32'd0);
    chk("flush_held_kept", 32'(held), 32'h047);
    pop_cnt = 0;
    tick(5);
    chk("flush_press_dropped", 32'(hit_count), 32'd0);
    chk("flush_no_hits", 32'(pop_cnt), 32'd0);
    btn_raw = '0;
    tick(12);
    chk("flush_release_held", 32'(held), 32'd0);

    // Reset in the middle of a debounce on btn 1, button kept pressed
    btn_raw[1] = 1'b1;
    tick(7);
    reset_n = 1'b0;
    #2;
    chk("midrst_held", 32'(held), 32'd0);
    chk("midrst_valid", 32'(hit_valid), 32'd0);
    chk("midrst_idx", 32'(hit_idx), 32'd0);
    chk("midrst_count", 32'(hit_count), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    tick(2);
    reset_n = 1'b1;
    sb.push_back(1);
    pop_cnt = 0;
    tick(9);
    chk("midrst_held_early", 32'(held), 32'd0);
    tick(1);
    chk("midrst_held_rise", 32'(held), 32'h002);
    chk("midrst_valid_early", 32'(hit_valid), 32'd0);
    tick(1);
    chk("midrst_hit_valid", 32'(hit_valid), 32'd1);
    chk("midrst_hit_idx", 32'(hit_idx), 32'd1);
    drain(10);
    chk("midrst_one_hit", 32'(pop_cnt), 32'd1);
    btn_raw = '0;
    tick(12);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
